// File: rtl/tcm_lsu_ctrl_if.sv
// Core memory-stage request/response channels plus the single-port TCM SRAM port.
// Pure wiring: no logic and no added latency.
// Backpressure travels on req_ready and rsp_ready. The SRAM port has no flow control.
interface tcm_lsu_ctrl_if #(
    parameter int AW     = 32,
    parameter int RAM_AW = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AW-1:0]     req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [3:0]        ram_wem;
    logic [31:0]       ram_dout;

    // Core plus SRAM side.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  ram_addr, ram_din, ram_we, ram_wem,
        output ram_dout
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output ram_addr, ram_din, ram_we, ram_wem,
        input  ram_dout
    );
endinterface

// File: rtl/tcm_lsu_ctrl.sv
// Byte/half/word load-store initiator for a single-port TCM with registered-address read.
// Latency: store response at T+1 and load response at T+2, one request in flight.
// Backpressure: req_ready only in IDLE, and the response is held until rsp_ready.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module tcm_lsu_ctrl #(
    parameter int AW     = 32,
    parameter int RAM_AW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    tcm_lsu_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t            state, state_nxt;
    logic [RAM_AW-1:0] req_word;
    logic [RAM_AW-1:0] waddr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [1:0]        off;
    logic [1:0]        eff_size;
    logic              req_err;
    logic              accept;
    logic [3:0]        st_wem;
    logic [31:0]       st_din;
    logic [31:0]       ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              ram_we_c;
    logic [3:0]        ram_wem_c;
    logic [31:0]       ram_din_c;
    logic [RAM_AW-1:0] ram_addr_c;

    assign off      = bus.req_addr[1:0];
    assign req_word = RAM_AW'(bus.req_addr >> 2);
    assign accept   = (state == IDLE) && bus.req_valid;

    // Size decode. Reserved size 2'b11 folds into word, and the check flags misalignment.
    always_comb begin
        eff_size = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
`ifdef LSU_MISALIGN_CHECK_EN
        req_err = ((bus.req_size == 2'b01) && off[0]) ||
                  ((bus.req_size == 2'b10) && (off != 2'b00)) ||
                  (bus.req_size == 2'b11);
`else
        req_err = 1'b0;
`endif
    end

    // Store lane mask and lane-replicated write data.
    always_comb begin
        st_wem = 4'b1111;
        st_din = bus.req_wdata;
        case (eff_size)
            2'b00: begin
                st_wem = 4'b0001 << off;
                st_din = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_wem = off[1] ? 4'b1100 : 4'b0011;
                st_din = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_wem = 4'b1111;
                st_din = bus.req_wdata;
            end
        endcase
    end

    // Load lane extraction and extension from the SRAM read word.
    always_comb begin
        ld_byte = bus.ram_dout[8*off_q +: 8];
        ld_half = off_q[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = bus.ram_dout;
        endcase
    end

    // State register. Reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and SRAM port drive. The write strobe is gated by rst_n so it drops at once on reset.
    always_comb begin
        state_nxt  = state;
        ram_we_c   = 1'b0;
        ram_wem_c  = 4'b0000;
        ram_din_c  = 32'd0;
        ram_addr_c = waddr_q;
        case (state)
            IDLE: begin
                ram_addr_c = req_word;
                if (bus.req_valid) begin
                    state_nxt = (bus.req_we || req_err) ? RESP : RD;
                    if (bus.req_we && !req_err && rst_n) begin
                        ram_we_c  = 1'b1;
                        ram_wem_c = st_wem;
                        ram_din_c = st_din;
                    end
                end
            end
            RD:      state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request attributes are latched at accept, and the load result is captured in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q     <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            waddr_q     <= req_word;
            off_q       <= off;
            size_q      <= eff_size;
            uns_q       <= bus.req_unsigned;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= req_err;
        end else if (state == RD) begin
            rsp_rdata_q <= ld_data;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_wem   = ram_wem_c;
    assign bus.ram_din   = ram_din_c;
endmodule

// File: tb/tb_tcm_lsu_ctrl.sv
// Directed bench for tcm_lsu_ctrl with a behavioural single-port SRAM model.
// Each request is checked for its SRAM port drive, response latency and result data.
// Also covers backpressure, throughput, misalignment handling and reset mid-operation.
module tb_tcm_lsu_ctrl;
    localparam int DP = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcm_lsu_ctrl_if #(.AW(32), .RAM_AW(32)) bus ();
    tcm_lsu_ctrl #(.AW(32), .RAM_AW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [DP];
    logic [8:0]  raddr = 9'd0;
    assign bus.ram_dout = mem[raddr];

    // SRAM model: byte-masked write on a write edge, address registered on a non-write edge.
    always @(posedge clk) begin
        if (bus.ram_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_wem[b]) mem[bus.ram_addr[8:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
        end else begin
            raddr <= bus.ram_addr[8:0];
        end
    end

    int cyc = 0;
    int we_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.ram_we === 1'b1) we_cnt <= we_cnt + 1;

    int errors = 0;
    int checks = 0;

    logic        t_we;
    logic [3:0]  t_wem;
    logic [31:0] t_din;
    logic [31:0] t_addr;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc_cyc;

    // One request: records the SRAM drive in the accept cycle, the response latency and the response data.
    task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
        int n;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        t_we = bus.ram_we; t_wem = bus.ram_wem; t_din = bus.ram_din; t_addr = bus.ram_addr;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        lat = -1; n = 0; rd = 32'hx; er = 1'bx;
        while (lat < 0 && n < 20) begin
            @(negedge clk); n++;
            if (bus.rsp_valid === 1'b1) begin lat = n; rd = bus.rsp_rdata; er = bus.rsp_err; end
        end
        if (lat >= 0) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h10; bus.req_wdata = 32'hFFFF_FFFF;
        #12;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", bus.ram_we); end
        checks++; if (bus.ram_wem !== 4'b0) begin errors++; $display("FAIL rst_ram_wem got %b want 0", bus.ram_wem); end
        checks++; if (bus.ram_din !== 32'd0) begin errors++; $display("FAIL rst_ram_din got %h want 0", bus.ram_din); end
        checks++; if (bus.ram_addr !== 32'd4) begin errors++; $display("FAIL rst_ram_addr got %h want 4", bus.ram_addr); end
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word;
        txn(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
        checks++; if (t_addr !== 32'd2) begin errors++; $display("FAIL sw_addr got %h want 2", t_addr); end
        checks++; if (t_we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", t_we); end
        checks++; if (t_wem !== 4'b1111) begin errors++; $display("FAIL sw_wem got %b want 1111", t_wem); end
        checks++; if (t_din !== 32'h1234_5678) begin errors++; $display("FAIL sw_din got %h want 12345678", t_din); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d want 1", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", er, rd); end
        checks++; if (mem[2] !== 32'h1234_5678) begin errors++; $display("FAIL sw_mem got %h want 12345678", mem[2]); end
    endtask

    task automatic test_store_byte;
        txn(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344);
        txn(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB);
        checks++; if (t_addr !== 32'd1) begin errors++; $display("FAIL sb_addr got %h want 1", t_addr); end
        checks++; if (t_wem !== 4'b0010) begin errors++; $display("FAIL sb_wem got %b want 0010", t_wem); end
        checks++; if (t_din !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_din got %h want abababab", t_din); end
        txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++; if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL sb_readback got %h want 1122ab44", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
    endtask

    task automatic test_load_extend;
        txn(1'b1, 2'b10, 1'b0, 32'hC, 32'h8001_80C3);
        txn(1'b0, 2'b00, 1'b0, 32'hD, 32'h0);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency got %0d want 2", lat); end
        txn(1'b0, 2'b00, 1'b1, 32'hD, 32'h0);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", rd); end
        txn(1'b0, 2'b01, 1'b0, 32'hE, 32'h0);
        checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed got %h want ffff8001", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lh_latency got %0d want 2", lat); end
        txn(1'b0, 2'b01, 1'b1, 32'hE, 32'h0);
        checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h want 00008001", rd); end
        txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF);
        checks++; if (t_addr !== 32'd4 || t_wem !== 4'b1100 || t_din !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL sh_drive got addr=%h wem=%b din=%h want 4/1100/beefbeef", t_addr, t_wem, t_din); end
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++; if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL sh_readback got %h want ffffbeef", rd); end
    endtask

    task automatic test_backpressure;
        int n;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'hC;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid !== 1'b1 && n < 10);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout rsp_valid=%b after %0d cycles", bus.rsp_valid, n); end
        @(posedge clk); #1;
        // A held load request must be ignored while the response waits.
        bus.req_valid = 1'b1; bus.req_addr = 32'h8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h8001_80C3 || bus.rsp_err !== 1'b0 ||
                bus.req_ready !== 1'b0 || bus.ram_we !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h err=%b rdy=%b we=%b want 1/800180c3/0/0/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.ram_we);
            end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_next_accept req_ready got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid !== 1'b1 && n < 10);
        checks++; if (n !== 2 || bus.rsp_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL bp_next_load got lat=%0d rdata=%h want 2/12345678", n, bus.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int a0;
        txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_0001);
        a0 = acc_cyc;
        txn(1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5_0002);
        checks++; if (acc_cyc - a0 !== 2) begin errors++; $display("FAIL b2b_store got %0d cycles want 2", acc_cyc - a0); end
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        a0 = acc_cyc;
        txn(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        checks++; if (acc_cyc - a0 !== 3) begin errors++; $display("FAIL b2b_load got %0d cycles want 3", acc_cyc - a0); end
        checks++; if (rd !== 32'hA5A5_0002) begin errors++; $display("FAIL b2b_data got %h want a5a50002", rd); end
    endtask

    task automatic test_misalign;
        int w0;
`ifdef LSU_MISALIGN_CHECK_EN
        txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++; $display("FAIL mis_lw got err=%b rdata=%h lat=%0d want 1/0/1", er, rd, lat); end
        w0 = we_cnt;
        txn(1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF);
        checks++; if (er !== 1'b1 || we_cnt !== w0 || lat !== 1) begin
            errors++; $display("FAIL mis_sw got err=%b writes=%0d lat=%0d want 1/0/1", er, we_cnt - w0, lat); end
        txn(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_rsvd got err=%b rdata=%h want 1/0", er, rd); end
`else
        txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        checks++; if (er !== 1'b0 || rd !== 32'h1122_AB44 || lat !== 2) begin
            errors++; $display("FAIL mis_lw got err=%b rdata=%h lat=%0d want 0/1122ab44/2", er, rd, lat); end
        txn(1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
        checks++; if (rd !== 32'hFFFF_AB44) begin errors++; $display("FAIL mis_lh got %h want ffffab44", rd); end
        w0 = we_cnt;
        txn(1'b1, 2'b11, 1'b0, 32'h2A, 32'h0BAD_CAFE);
        checks++; if (er !== 1'b0 || we_cnt - w0 !== 1 || t_wem !== 4'b1111 || mem[10] !== 32'h0BAD_CAFE) begin
            errors++; $display("FAIL mis_rsvd_sw got err=%b writes=%0d wem=%b mem=%h want 0/1/1111/0badcafe",
                               er, we_cnt - w0, t_wem, mem[10]); end
`endif
    endtask

    task automatic test_reset_mid;
        txn(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.ram_we !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid got valid=%b we=%b rdy=%b want 0/0/1", bus.rsp_valid, bus.ram_we, bus.req_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++; if (rd !== 32'hCAFE_F00D || lat !== 2) begin
            errors++; $display("FAIL rst_after_load got rdata=%h lat=%0d want cafef00d/2", rd, lat); end
    endtask

    initial begin
        for (int i = 0; i < DP; i++) mem[i] = 32'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_extend();
        test_backpressure();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
